// File: rtl/encoder_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : encoder_defs_pkg
// Brief    : Shared widths, FSM state codes and defaults for the arbiter and
//            the downstream 8-to-3 encoder.
// Revision : 1.0
// ============================================================================
package encoder_defs_pkg;

  localparam int LINES            = 8;
  localparam int IDX_W            = 3;
  localparam int HOLD_W           = 8;
  localparam int MAX_HOLD_DEFAULT = 16;

  localparam int         ST_W     = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

endpackage : encoder_defs_pkg
`default_nettype wire

// File: rtl/rr_pick_8.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_8
// Brief    : Combinational round-robin picker; rotates the request vector so
//            the bit after the pointer sits at position 0, then applies a
//            fixed lowest-index-first priority.
// Revision : 1.0
// ============================================================================
module rr_pick_8
  import encoder_defs_pkg::*;
(
  input  logic [LINES-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [LINES-1:0] pick_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0]   start;
  logic [2*LINES-2:0] req_dbl;
  logic [LINES-1:0]   rot;
  logic [IDX_W-1:0]   offset;
  logic               found;

  // Search begins one past the last owner; modulo-8 wrap comes from IDX_W.
  assign start   = ptr_i + IDX_W'(1);
  assign req_dbl = {req_i[LINES-2:0], req_i};
  assign rot     = req_dbl[start +: LINES];

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int k = LINES - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = IDX_W'(k);
        found  = 1'b1;
      end
    end
  end

  assign idx_o  = found ? (start + offset) : '0;
  assign pick_o = found ? (LINES'(1) << idx_o) : '0;

endmodule : rr_pick_8
`default_nettype wire

// File: rtl/onehot_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : onehot_rr_arbiter_8
// Brief    : 8-way round-robin arbiter with registered one-hot grant and a
//            mandatory one-cycle TURN gap; optional hold timeout under
//            macro ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module onehot_rr_arbiter_8
  import encoder_defs_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LINES-1:0] in_lines,
  input  logic             release_i,  // "release" is a reserved word
  output logic [LINES-1:0] out_lines,
  output logic             grant_valid,
  output logic             timeout_flag
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("onehot_rr_arbiter_8: MAX_HOLD must be within 2..255");
  end

  logic [ST_W-1:0]  state_q, state_d;
  logic [LINES-1:0] out_q, out_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;

  logic [LINES-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             natural_exit;
  logic             timeout_hit;
  logic             grant_exit;

  rr_pick_8 u_pick (
    .req_i  (in_lines),
    .ptr_i  (last_idx_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

  // Withdrawal and release together collapse into one exit.
  assign natural_exit = release_i | ~in_lines[cur_idx_q];
  assign grant_exit   = (state_q == ST_GRANT) && (natural_exit || timeout_hit);

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  assign timeout_hit = (state_q == ST_GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d    = '0;
    timeout_d = 1'b0;
    if (state_q == ST_GRANT) begin
      if (!grant_exit) begin
        hold_d = hold_q + HOLD_W'(1);
      end
      timeout_d = timeout_hit && !natural_exit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|in_lines) state_d = ST_GRANT;
      ST_GRANT: if (grant_exit) state_d = ST_TURN;
      ST_TURN:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d      = out_q;
    cur_idx_d  = cur_idx_q;
    last_idx_d = last_idx_q;
    case (state_q)
      ST_IDLE: begin
        // pick is all-zero when nothing is requested
        out_d     = pick;
        cur_idx_d = pick_idx;
      end
      ST_GRANT: begin
        if (grant_exit) begin
          out_d      = '0;
          last_idx_d = cur_idx_q;
        end
      end
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      cur_idx_q  <= '0;
      last_idx_q <= IDX_W'(LINES - 1);
    end else begin
      out_q      <= out_d;
      cur_idx_q  <= cur_idx_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign out_lines   = out_q;
  assign grant_valid = |out_q;

endmodule : onehot_rr_arbiter_8
`default_nettype wire
